i2s_receiver: RTL and testbench

- I2S slave receiver; the far end of the link driven by i2s_master.
- Oversamples external BCLK/LRCLK/SDATA with clk_i, deserialises 24-bit MSB-first samples from 32-bit slots (standard I2S one-bit delay), and presents left/right pairs with a one-cycle valid strobe.
- Sits between the codec/ADC pins and the audio processing pipeline.

---
 rtl/i2s_pkg.sv | 11 +
 rtl/i2s_sync_edge.sv | 29 ++
 rtl/i2s_receiver.sv | 125 ++++++++++++
 tb/tb_i2s_receiver.sv | 131 +++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// i2s_pkg: shared FSM states, default widths and sample-pair type for the I2S receiver.
package i2s_pkg;
  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;
  localparam int I2S_FRAME_BITS = 2 * I2S_SLOT_WIDTH;
  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_e;
  typedef struct packed {
    logic [I2S_DATA_WIDTH-1:0] left;
    logic [I2S_DATA_WIDTH-1:0] right;
  } sample_pair_t;
endpackage

// File: rtl/i2s_sync_edge.sv
// i2s_sync_edge: STAGES-deep synchroniser per bit, registered output plus a one-cycle rising-edge strobe.
module i2s_sync_edge #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o
);
  logic [STAGES-1:0][W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end
  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver: oversampling I2S slave, deserialises MSB-first left/right samples with a pair-valid strobe.
// Optional framing check enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH  = I2S_SLOT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic                  i2s_bclk_i,
  input  logic                  i2s_lrclk_i,
  input  logic                  i2s_data_i,
  output logic [DATA_WIDTH-1:0] left_o,
  output logic [DATA_WIDTH-1:0] right_o,
  output logic                  valid_o,
  output logic                  frame_err_o
);
  localparam int SW = $clog2(SLOT_WIDTH);
  localparam logic [SW-1:0] SLOT_MAX = SW'(SLOT_WIDTH - 1);
  localparam logic [SW-1:0] SLOT_DW  = SW'(DATA_WIDTH);
  logic strobe, lr_s, dat_s, unused_bclk;
  logic [1:0] unused_rise;
  i2s_sync_edge #(.STAGES(SYNC_STAGES), .W(1)) u_bclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(i2s_bclk_i), .q_o(unused_bclk), .rise_o(strobe)
  );
  i2s_sync_edge #(.STAGES(SYNC_STAGES), .W(2)) u_lrdat (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i({i2s_lrclk_i, i2s_data_i}), .q_o({lr_s, dat_s}),
    .rise_o(unused_rise)
  );
  state_e state_q, state_d;
  logic [SW-1:0] slot_q, slot_d, slot_inc;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, hold_q, hold_d, left_q, left_d, right_q, right_d;
  logic lr_prev_q, lr_prev_d, valid_q, valid_d, upd_q, upd_d, ws_edge;
  assign ws_edge = strobe & (lr_s != lr_prev_q);
  always_comb begin
    slot_inc  = (slot_q == SLOT_MAX) ? slot_q : slot_q + 1'b1;
    state_d   = state_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    upd_d     = strobe;
    lr_prev_d = strobe ? lr_s : lr_prev_q;
    if (!enable_i) begin
      state_d = SYNC;
      slot_d  = '0;
      upd_d   = 1'b0;
    end else if (ws_edge) begin
      slot_d  = '0;
      hold_d  = (state_q == LEFT) ? shift_q : hold_q;
      state_d = (state_q == SYNC) ? (lr_s ? SYNC : LEFT) :
                (state_q == LEFT) ? ((slot_q >= SLOT_DW) ? RIGHT : SYNC) : LEFT;
    end else if (strobe) begin
      slot_d  = slot_inc;
      shift_d = (slot_inc <= SLOT_DW) ? {shift_q[DATA_WIDTH-2:0], dat_s} : shift_q;
    end
    // commit one cycle after the strobe that shifted in the right-channel LSB
    if (enable_i && upd_q && state_q == RIGHT && slot_q == SLOT_DW) begin
      left_d  = hold_q;
      right_d = shift_q;
      valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SYNC;
      slot_q    <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      lr_prev_q <= lr_prev_d;
    end
  end
  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam logic [SW:0] CNT_FULL = (SW+1)'(SLOT_WIDTH);
  logic [SW:0] cnt_q, cnt_d;
  logic err_q, err_d;
  // counts every strobe of the half frame, including the slot-0 strobe itself
  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (!enable_i) begin
      cnt_d = '0;
    end else if (ws_edge) begin
      cnt_d = (SW+1)'(1);
      err_d = (state_q != SYNC) && (cnt_q != CNT_FULL);
    end else if (strobe) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign frame_err_o = err_q;
`else
  assign frame_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver: bit-level I2S driver with a frame-level expectation queue for i2s_receiver.
module tb_i2s_receiver;
  import i2s_pkg::*;
  localparam int S = 2;
`ifdef I2S_RX_FRAME_CHECK_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif
  logic clk = 0, rst_n = 0, en = 1, bclk = 0, lr = 1, dat = 0;
  logic [23:0] left_o, right_o;
  logic valid_o, ferr;
  int nvec = 0, nbad = 0, cyc = 0, rcyc = 0, lsb = 0, nvalid = 0, nerr = 0, npush = 0;
  bit pl = 0, lok = 0, vp = 0;
  logic [23:0] lpend = '0;
  sample_pair_t expq[$];
  sample_pair_t last = '0;

  i2s_receiver #(.DATA_WIDTH(24), .SLOT_WIDTH(32), .SYNC_STAGES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en), .i2s_bclk_i(bclk), .i2s_lrclk_i(lr),
    .i2s_data_i(dat), .left_o(left_o), .right_o(right_o), .valid_o(valid_o), .frame_err_o(ferr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sample_pair_t e;
    if (ferr) nerr++;
    if (valid_o) begin
      nvalid++;
      chk("pulse_width", vp, 0);
      if (expq.size() == 0) chk("spurious_valid", expq.size(), 1);
      else begin
        e = expq.pop_front();
        chk("left", left_o, e.left);
        chk("right", right_o, e.right);
        chk("latency", cyc - lsb, S + 2);
      end
    end
    vp = valid_o;
  end

  // one BCLK period: low half then high half, three clk periods each
  task automatic slot(input bit l, input bit d);
    bclk = 0; lr = l; dat = d;
    repeat (3) @(posedge clk);
    #1 bclk = 1; rcyc = cyc;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic chan(input bit l, input logic [23:0] s, input int n, input int st, input bit kill);
    sample_pair_t p;
    if (!l) begin
      lok = pl && en && st == 0 && n >= 25;
      lpend = s;
    end else begin
      if (lok && !pl && st == 0 && n >= 25 && en && !kill) begin
        p.left = lpend; p.right = s;
        expq.push_back(p); last = p; npush++;
      end
      lok = 0;
    end
    pl = l;
    for (int i = st; i < n; i++) begin
      bit d;
      d = (i >= 1 && i <= 24) ? s[24-i] : 1'($urandom);
      if (kill && i == 10) begin
        rst_n = 0;
        #2;
        chk("rst_left", left_o, 0);
        chk("rst_right", right_o, 0);
        chk("rst_valid", valid_o, 0);
        rst_n = 1;
      end
      slot(l, d);
      if (l && i == 24) lsb = rcyc;
    end
  endtask

  task automatic frame(input logic [23:0] a, input logic [23:0] b);
    chan(0, a, 32, 0, 0);
    chan(1, b, 32, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_left", left_o, 0);
    chk("reset_right", right_o, 0);
    chk("reset_valid", valid_o, 0);
    chk("reset_err", ferr, 0);
    @(posedge clk);
    #1 rst_n = 1;
    chan(1, 24'($urandom), 32, 10, 0);
    frame(24'h5A5AC2, 24'hDA5AC3);
    repeat (3) frame(24'h9A5AC3, 24'h9A5AC3);
    chan(0, 24'($urandom), 20, 0, 0);
    chan(1, 24'($urandom), 32, 0, 0);
    frame(24'($urandom), 24'($urandom));
    chan(0, 24'($urandom), 32, 0, 0);
    chan(1, 24'($urandom), 20, 0, 0);
    frame(24'($urandom), 24'($urandom));
    en = 0;
    repeat (3) frame(24'($urandom), 24'($urandom));
    chk("hold_left", left_o, last.left);
    chk("hold_right", right_o, last.right);
    en = 1;
    repeat (2) frame(24'($urandom), 24'($urandom));
    chan(0, 24'($urandom), 32, 0, 0);
    chan(1, 24'($urandom), 32, 0, 1);
    repeat (2) frame(24'($urandom), 24'($urandom));
    repeat (100) frame(24'($urandom), 24'($urandom));
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("valid_count", nvalid, npush);
    chk("queue_empty", expq.size(), 0);
    chk("frame_err_count", nerr, EXP_ERR);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
